alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares one combinational ALU instance (32-bit instruction, regA, regB in; 32-bit result, 3-bit flags out) between two requesters, e.g. the EX stage and a debug/test port.
- Round-robin arbitration, valid/ready handshakes on request and response, operand latching, registered result/flags.
- Sits between requesters and the ALU; the ALU itself is instantiated outside this block.

Parameters:
- CNT_W, 16, width of the optional per-requester completion counters (ALU_PERF_CNT_EN only).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  2  bit i = requester i presents an operation.
- req_ready  out  2  bit i = requester i's operation accepted this cycle (one-hot or zero).
- req_instr0 / req_instr1  in  32  instruction word, requester 0 / 1.
- req_rega0 / req_rega1  in  32  regA operand, requester 0 / 1.
- req_regb0 / req_regb1  in  32  regB operand, requester 0 / 1.
- alu_instruction  out  32  to ALU instruction input.
- alu_rega  out  32  to ALU regA input.
- alu_regb  out  32  to ALU regB input.
- alu_result  in  32  from ALU result.
- alu_flags  in  3  from ALU flags: [0] zero/branch, [1] negative/less-than, [2] overflow.
- rsp_valid  out  2  bit i = response pending for requester i (one-hot or zero).
- rsp_ready  in  2  bit i = requester i consumes its response.
- rsp_result  out  32  captured ALU result.
- rsp_flags  out  3  captured ALU flags.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (async, rst=1): state=IDLE; rr_ptr=0 (requester 0 preferred first); req_ready=0; rsp_valid=0; rsp_result=0; rsp_flags=0; operand latches=0; alu_* outputs=0; busy=0. Reset mid-operation abandons the op; no response is issued.
- FSM states:
  - IDLE: req_ready is combinational.
    - If exactly one req_valid bit is set, that requester is granted.
    - If both are set, grant rr_ptr.
    - On grant, req_ready[g]=1 that cycle; latch instr/rega/regb and grant id g at the edge; go EXEC.
    - No valid: stay IDLE.
  - EXEC: drive latched operands on alu_*; at the edge capture alu_result and alu_flags into rsp_result/rsp_flags; go RESP.
  - RESP: rsp_valid[g]=1, stable until rsp_ready[g]=1.
    - On handshake: rsp_valid cleared next cycle; rr_ptr = ~g; go IDLE.
    - rsp_ready on the non-granted bit is ignored.
- Latency: accepted at edge N; rsp_valid high from edge N+1; minimum 3 cycles per op (IDLE, EXEC, RESP). No new request is accepted outside IDLE.
- alu_* outputs hold the last latched values in IDLE/RESP (not cleared), so the ALU output is stable.
- Requesters must hold req_* stable while valid and not ready; the block never drops a valid request.
- Fairness: with both valid continuously, grants alternate 0,1,0,1...
- Flags and result pass through unmodified. No interpretation of overflow, so add overflow (flags=3'b100) is delivered as-is.
- Data captured in RESP is never overwritten until the response handshake completes.

Optional Feature:
- Macro ALU_PERF_CNT_EN.
- Defined:
  - Adds outputs op_cnt0 and op_cnt1 (CNT_W each) counting completed response handshakes per requester, saturating at all-ones.
  - Adds ovf_cnt (CNT_W), counting completions with rsp_flags[2]=1, also saturating.
  - All counters reset to 0 on rst.
  - Adds input cnt_clr (1 bit): synchronous clear of all counters; clear wins over a simultaneous increment.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset: assert rst mid-EXEC (op addi, regA=5) -> all outputs 0 immediately, state IDLE, no rsp_valid after deassert.
- Single add: req0 instr=0x00000020, regA=3, regB=4, ALU model = behavioural adder -> req_ready=2'b01 one cycle, rsp_valid=2'b01 two edges later, rsp_result=7, rsp_flags=3'b000.
- Contention: both valid continuously, 4 ops each -> grant order 0,1,0,1,0,1,0,1; each rsp_result matches its own operands.
- Backpressure: rsp_ready held 0 for 10 cycles after add 0x7FFFFFFF+1 -> rsp_valid, rsp_result=0x80000000 and rsp_flags=3'b100 stable all 10 cycles; req_ready stays 0; wrong-bit rsp_ready ignored.
- Idle gap: req1 only, beq with regA=regB=9 -> rsp_valid=2'b10, rsp_flags=3'b001; rr_ptr then prefers 0.
- ALU_PERF_CNT_EN: 3 ops from req0 (one overflowing), 2 from req1, then cnt_clr together with a completion -> op_cnt0=3, op_cnt1=2, ovf_cnt=1 before the clear; all 0 after it.

Source files
------------

// File: rtl/alu_share_arbiter_if.sv
// Handshake and ALU-facing bus of alu_share_arbiter.
// slave = the arbiter; master = requesters plus the external ALU.
interface alu_share_arbiter_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_instr0;
  logic [31:0] req_instr1;
  logic [31:0] req_rega0;
  logic [31:0] req_rega1;
  logic [31:0] req_regb0;
  logic [31:0] req_regb1;
  logic [31:0] alu_instruction;
  logic [31:0] alu_rega;
  logic [31:0] alu_regb;
  logic [31:0] alu_result;
  logic [2:0]  alu_flags;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_result;
  logic [2:0]  rsp_flags;
  logic        busy;

  modport slave (
    input  req_valid, req_instr0, req_instr1, req_rega0, req_rega1, req_regb0, req_regb1,
    output req_ready,
    output alu_instruction, alu_rega, alu_regb,
    input  alu_result, alu_flags,
    output rsp_valid, rsp_result, rsp_flags, busy,
    input  rsp_ready
  );

  modport master (
    output req_valid, req_instr0, req_instr1, req_rega0, req_rega1, req_regb0, req_regb1,
    input  req_ready,
    input  alu_instruction, alu_rega, alu_regb,
    output alu_result, alu_flags,
    input  rsp_valid, rsp_result, rsp_flags, busy,
    output rsp_ready
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one external combinational ALU between two requesters.
// Optional completion/overflow counters are built when ALU_PERF_CNT_EN is defined.
module alu_share_arbiter
`ifdef ALU_PERF_CNT_EN
#(
  parameter int unsigned CNT_W = 16
)
`endif
(
  input  logic               clk,
  input  logic               rst,
  alu_share_arbiter_if.slave bus
`ifdef ALU_PERF_CNT_EN
  ,
  input  logic               cnt_clr,
  output logic [CNT_W-1:0]   op_cnt0,
  output logic [CNT_W-1:0]   op_cnt1,
  output logic [CNT_W-1:0]   ovf_cnt
`endif
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e      r_state;
  state_e      w_state_next;
  logic        r_rr_ptr;
  logic        r_gnt;
  logic [31:0] r_instr;
  logic [31:0] r_rega;
  logic [31:0] r_regb;
  logic [31:0] r_result;
  logic [2:0]  r_flags;

  logic        w_gnt_vld;
  logic        w_gnt_id;
  logic        w_accept;
  logic        w_rsp_hs;

  // Single requester wins outright; a tie goes to the round-robin pointer.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_id  = 1'b0;
    case (bus.req_valid)
      2'b01: begin
        w_gnt_vld = 1'b1;
        w_gnt_id  = 1'b0;
      end
      2'b10: begin
        w_gnt_vld = 1'b1;
        w_gnt_id  = 1'b1;
      end
      2'b11: begin
        w_gnt_vld = 1'b1;
        w_gnt_id  = r_rr_ptr;
      end
      default: ;
    endcase
  end

  assign w_accept = (r_state == StIdle) && w_gnt_vld;
  assign w_rsp_hs = (r_state == StResp) && bus.rsp_ready[r_gnt];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:  if (w_accept) w_state_next = StExec;
      StExec:  w_state_next = StResp;
      StResp:  if (w_rsp_hs) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    bus.req_ready = 2'b00;
    bus.rsp_valid = 2'b00;
    bus.busy      = (r_state != StIdle);
    if (w_accept) begin
      bus.req_ready = w_gnt_id ? 2'b10 : 2'b01;
    end
    if (r_state == StResp) begin
      bus.rsp_valid = {r_gnt, ~r_gnt};
    end
  end

  // Operand latches only load on accept, so the ALU inputs hold steady through RESP/IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= 1'b0;
      r_gnt    <= 1'b0;
      r_instr  <= '0;
      r_rega   <= '0;
      r_regb   <= '0;
      r_result <= '0;
      r_flags  <= '0;
    end else begin
      if (w_accept) begin
        r_gnt   <= w_gnt_id;
        r_instr <= w_gnt_id ? bus.req_instr1 : bus.req_instr0;
        r_rega  <= w_gnt_id ? bus.req_rega1  : bus.req_rega0;
        r_regb  <= w_gnt_id ? bus.req_regb1  : bus.req_regb0;
      end
      if (r_state == StExec) begin
        r_result <= bus.alu_result;
        r_flags  <= bus.alu_flags;
      end
      if (w_rsp_hs) begin
        r_rr_ptr <= ~r_gnt;
      end
    end
  end

  assign bus.alu_instruction = r_instr;
  assign bus.alu_rega        = r_rega;
  assign bus.alu_regb        = r_regb;
  assign bus.rsp_result      = r_result;
  assign bus.rsp_flags       = r_flags;

`ifdef ALU_PERF_CNT_EN
  logic [CNT_W-1:0] r_op_cnt0;
  logic [CNT_W-1:0] r_op_cnt1;
  logic [CNT_W-1:0] r_ovf_cnt;

  // Clear has priority over a completion in the same cycle; counters saturate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op_cnt0 <= '0;
      r_op_cnt1 <= '0;
      r_ovf_cnt <= '0;
    end else if (cnt_clr) begin
      r_op_cnt0 <= '0;
      r_op_cnt1 <= '0;
      r_ovf_cnt <= '0;
    end else if (w_rsp_hs) begin
      if (!r_gnt && (r_op_cnt0 != '1)) r_op_cnt0 <= r_op_cnt0 + CNT_W'(1);
      if (r_gnt && (r_op_cnt1 != '1))  r_op_cnt1 <= r_op_cnt1 + CNT_W'(1);
      if (r_flags[2] && (r_ovf_cnt != '1)) r_ovf_cnt <= r_ovf_cnt + CNT_W'(1);
    end
  end

  assign op_cnt0 = r_op_cnt0;
  assign op_cnt1 = r_op_cnt1;
  assign ovf_cnt = r_ovf_cnt;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter with a behavioural ALU and arbitration model.
module tb_alu_share_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_share_arbiter_if bus();

  logic        v0 = 1'b0;
  logic        v1 = 1'b0;
  logic [31:0] t_instr [2];
  logic [31:0] t_rega  [2];
  logic [31:0] t_regb  [2];

  assign bus.req_valid  = {v1, v0};
  assign bus.req_instr0 = t_instr[0];
  assign bus.req_instr1 = t_instr[1];
  assign bus.req_rega0  = t_rega[0];
  assign bus.req_rega1  = t_rega[1];
  assign bus.req_regb0  = t_regb[0];
  assign bus.req_regb1  = t_regb[1];

`ifdef ALU_PERF_CNT_EN
  logic        cnt_clr = 1'b0;
  logic [15:0] op_cnt0;
  logic [15:0] op_cnt1;
  logic [15:0] ovf_cnt;

  alu_share_arbiter u_dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .cnt_clr (cnt_clr),
    .op_cnt0 (op_cnt0),
    .op_cnt1 (op_cnt1),
    .ovf_cnt (ovf_cnt)
  );
`else
  alu_share_arbiter u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );
`endif

  // Behavioural ALU: funct 0x20 add, 0x22 sub, 0x24 and, 0x2A slt; op 0x08 addi, 0x04 beq.
  // flags = {signed overflow, less-than, zero}
  function automatic logic [34:0] ref_alu(input logic [31:0] ins, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] r;
    logic [31:0] imm;
    logic        ovf;
    logic        lt;
    ovf = 1'b0;
    lt  = 1'b0;
    imm = {{16{ins[15]}}, ins[15:0]};
    case (ins[31:26])
      6'h00: begin
        case (ins[5:0])
          6'h20: begin
            r   = a + b;
            ovf = (a[31] == b[31]) && (r[31] != a[31]);
          end
          6'h22: begin
            r   = a - b;
            ovf = (a[31] != b[31]) && (r[31] != a[31]);
          end
          6'h2A: begin
            lt = $signed(a) < $signed(b);
            r  = {31'b0, lt};
          end
          default: r = a & b;
        endcase
      end
      6'h08: begin
        r   = a + imm;
        ovf = (a[31] == imm[31]) && (r[31] != a[31]);
      end
      6'h04:   r = a - b;
      default: r = 32'h0;
    endcase
    return {ovf, lt, (r == 32'h0), r};
  endfunction

  assign {bus.alu_flags, bus.alu_result} =
      ref_alu(bus.alu_instruction, bus.alu_rega, bus.alu_regb);

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    case ($urandom_range(0, 5))
      0:       r = 32'h0000_0020;
      1:       r = 32'h0000_0022;
      2:       r = 32'h0000_002A;
      3:       r = 32'h0000_0024;
      4:       r = {6'h08, 10'b0, 16'($urandom)};
      default: r = {6'h04, 26'b0};
    endcase
    return r;
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] r;
    case ($urandom_range(0, 3))
      0:       r = $urandom;
      1:       r = $urandom_range(0, 15);
      2:       r = 32'h7FFF_FFFF;
      default: r = 32'h8000_0000;
    endcase
    return r;
  endfunction

  typedef struct packed {
    logic        id;
    logic [31:0] res;
    logic [2:0]  flg;
  } exp_t;

  exp_t        sb_q[$];
  int          gnt_log[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          gnt_cyc = 0;
  logic        last_served = 1'b1;
  logic [1:0]  prev_rsp = 2'b00;
  logic [34:0] prev_data = '0;
  logic        mon_g;
  logic [34:0] mon_r;
  int          rsp_mode = 0;
  logic [1:0]  rsp_force = 2'b00;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: model grants and responses from the arbitration rules, compare at negedge.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        check("busy", bus.busy, sb_q.size() != 0);
        if (bus.req_ready != 2'b00) begin
          mon_g = (bus.req_valid == 2'b11) ? ~last_served : bus.req_valid[1];
          check("grant_while_busy", sb_q.size(), 0);
          check("grant", bus.req_ready, mon_g ? 2'b10 : 2'b01);
          mon_r = ref_alu(t_instr[mon_g], t_rega[mon_g], t_regb[mon_g]);
          sb_q.push_back(exp_t'{mon_g, mon_r[31:0], mon_r[34:32]});
          gnt_log.push_back(int'(mon_g));
          gnt_cyc = cyc;
        end
        if (bus.rsp_valid != 2'b00) begin
          if (sb_q.size() == 0) begin
            check("unexpected_rsp", bus.rsp_valid, 2'b00);
          end else begin
            if (prev_rsp == 2'b00) check("latency", cyc - gnt_cyc, 2);
            else check("rsp_stable", {bus.rsp_flags, bus.rsp_result}, prev_data);
            check("rsp_valid", bus.rsp_valid, sb_q[0].id ? 2'b10 : 2'b01);
            if ((bus.rsp_valid & bus.rsp_ready) != 2'b00) begin
              check("rsp_result", bus.rsp_result, sb_q[0].res);
              check("rsp_flags", bus.rsp_flags, sb_q[0].flg);
              last_served = sb_q[0].id;
              void'(sb_q.pop_front());
            end
          end
        end
        prev_rsp  = bus.rsp_valid & ~bus.rsp_ready;
        prev_data = {bus.rsp_flags, bus.rsp_result};
      end else begin
        prev_rsp = 2'b00;
      end
    end
  end

  initial begin
    bus.rsp_ready = 2'b00;
    forever begin
      @(posedge clk);
      #1;
      case (rsp_mode)
        0:       bus.rsp_ready = 2'b11;
        1:       bus.rsp_ready = 2'($urandom);
        default: bus.rsp_ready = rsp_force;
      endcase
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic issue(input int i, input logic [31:0] ins, input logic [31:0] a,
                       input logic [31:0] b);
    int t;
    t = 0;
    t_instr[i] = ins;
    t_rega[i]  = a;
    t_regb[i]  = b;
    if (i == 0) v0 = 1'b1;
    else v1 = 1'b1;
    do begin
      @(negedge clk);
      t++;
    end while (!bus.req_ready[i] && t < 200);
    check("accept", bus.req_ready[i], 1'b1);
    @(posedge clk);
    #1;
    if (i == 0) v0 = 1'b0;
    else v1 = 1'b0;
  endtask

  task automatic wait_rsp();
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (bus.rsp_valid == 2'b00 && t < 50);
    check("rsp_arrives", bus.rsp_valid != 2'b00, 1'b1);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((sb_q.size() != 0 || bus.busy) && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("drain", sb_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sb_q.delete();
    last_served = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic run_req(input int i, input int n, input bit gaps);
    int g;
    for (int k = 0; k < n; k++) begin
      if (gaps) begin
        g = $urandom_range(0, 3);
        if (g > 0) begin
          repeat (g) @(posedge clk);
          #1;
        end
      end
      issue(i, rand_instr(), rand_op(), rand_op());
    end
  endtask

  int base;

  initial begin
    for (int i = 0; i < 2; i++) begin
      t_instr[i] = '0;
      t_rega[i]  = '0;
      t_regb[i]  = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", bus.req_ready, 2'b00);
    check("rst_rsp_valid", bus.rsp_valid, 2'b00);
    check("rst_rsp_result", bus.rsp_result, 32'h0);
    check("rst_rsp_flags", bus.rsp_flags, 3'b000);
    check("rst_alu_instr", bus.alu_instruction, 32'h0);
    check("rst_alu_rega", bus.alu_rega, 32'h0);
    check("rst_busy", bus.busy, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Reset while the ALU op is in EXEC: everything clears and no response follows.
    issue(0, {6'h08, 10'b0, 16'h0001}, 32'd5, 32'd0);
    check("exec_busy", bus.busy, 1'b1);
    check("exec_alu_rega", bus.alu_rega, 32'd5);
    #2;
    rst = 1'b1;
    sb_q.delete();
    last_served = 1'b1;
    #1;
    check("midrst_alu_rega", bus.alu_rega, 32'h0);
    check("midrst_alu_instr", bus.alu_instruction, 32'h0);
    check("midrst_busy", bus.busy, 1'b0);
    check("midrst_rsp_valid", bus.rsp_valid, 2'b00);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("post_rst_no_rsp", bus.rsp_valid, 2'b00);
    end
    @(posedge clk);
    #1;

    // Single add.
    rsp_mode = 0;
    issue(0, 32'h0000_0020, 32'd3, 32'd4);
    wait_rsp();
    check("add_rsp_valid", bus.rsp_valid, 2'b01);
    check("add_result", bus.rsp_result, 32'd7);
    check("add_flags", bus.rsp_flags, 3'b000);
    wait_idle();

    // Backpressure with a wrong-bit rsp_ready while requester 1 waits.
    rsp_mode  = 2;
    rsp_force = 2'b10;
    issue(0, 32'h0000_0020, 32'h7FFF_FFFF, 32'd1);
    fork
      issue(1, 32'h0000_0020, 32'd10, 32'd20);
      begin
        wait_rsp();
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          check("bp_rsp_valid", bus.rsp_valid, 2'b01);
          check("bp_result", bus.rsp_result, 32'h8000_0000);
          check("bp_flags", bus.rsp_flags, 3'b100);
          check("bp_req_ready", bus.req_ready, 2'b00);
        end
        rsp_mode = 0;
      end
    join
    wait_idle();

    // Lone requester 1 beq, then a tie must go to requester 0.
    issue(1, {6'h04, 26'b0}, 32'd9, 32'd9);
    wait_rsp();
    check("beq_rsp_valid", bus.rsp_valid, 2'b10);
    check("beq_flags", bus.rsp_flags, 3'b001);
    wait_idle();
    base = gnt_log.size();
    fork
      issue(0, 32'h0000_0022, 32'd50, 32'd8);
      issue(1, 32'h0000_0024, 32'hF0F0, 32'hFF00);
    join
    wait_idle();
    check("tie_prefers_0", gnt_log[base], 0);

    // Contention: 4 ops each, both valid continuously.
    base = gnt_log.size();
    fork
      run_req(0, 4, 1'b0);
      run_req(1, 4, 1'b0);
    join
    wait_idle();
    check("contention_grants", gnt_log.size() - base, 8);
    for (int k = base + 1; k < gnt_log.size(); k++) begin
      check("alternate", gnt_log[k] != gnt_log[k-1], 1'b1);
    end

    // Randomized traffic with random gaps and random response backpressure.
    rsp_mode = 1;
    fork
      run_req(0, 25, 1'b1);
      run_req(1, 25, 1'b1);
    join
    rsp_mode = 0;
    wait_idle();

`ifdef ALU_PERF_CNT_EN
    do_reset();
    issue(0, 32'h0000_0020, 32'd1, 32'd2);
    wait_idle();
    issue(0, 32'h0000_0020, 32'h7FFF_FFFF, 32'd1);
    wait_idle();
    issue(0, 32'h0000_0022, 32'd5, 32'd3);
    wait_idle();
    issue(1, 32'h0000_0020, 32'd2, 32'd2);
    wait_idle();
    issue(1, 32'h0000_0024, 32'hFF, 32'h0F);
    wait_idle();
    check("op_cnt0", op_cnt0, 16'd3);
    check("op_cnt1", op_cnt1, 16'd2);
    check("ovf_cnt", ovf_cnt, 16'd1);
    rsp_mode  = 2;
    rsp_force = 2'b00;
    issue(0, 32'h0000_0020, 32'd1, 32'd1);
    wait_rsp();
    rsp_force = 2'b01;
    @(posedge clk);
    #2;
    cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr  = 1'b0;
    rsp_mode = 0;
    check("clr_op_cnt0", op_cnt0, 16'd0);
    check("clr_op_cnt1", op_cnt1, 16'd0);
    check("clr_ovf_cnt", ovf_cnt, 16'd0);
    wait_idle();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
